state_seq: RTL and testbench

Sequencer FSM that owns the 4-bit `state` field driven onto the shared `intf` bundle and consumed by the downstream `dut` state monitor. It accepts next-state requests over a valid/ready handshake and commits only legal transitions, after a minimum dwell time. It forces a return to state 0 on abort or dwell timeout. The monitor's rule, that entry to state 1 is legal only from 0, 3 or 5, is guaranteed by construction.

---
 rtl/state_seq_pkg.sv | 42 ++++
 rtl/state_seq.sv | 107 ++++++++++
 tb/tb_state_seq.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/state_seq_pkg.sv
// Shared definitions for the state sequencer and the downstream state monitor.
// The transition table lives here so both sides agree on what is legal.
package state_seq_pkg;

  localparam int NUM_STATES = 8;

  typedef enum logic [3:0] {
    S0 = 4'd0,
    S1 = 4'd1,
    S2 = 4'd2,
    S3 = 4'd3,
    S4 = 4'd4,
    S5 = 4'd5,
    S6 = 4'd6,
    S7 = 4'd7
  } state_t;

  // Returns 1 when moving from cur to nxt is allowed; staying put is always allowed.
  function automatic logic legal_next(input logic [3:0] cur, input logic [3:0] nxt);
    logic ok;
    ok = 1'b0;
    if (int'(nxt) >= NUM_STATES) begin
      ok = 1'b0;
    end else if (cur == nxt) begin
      ok = 1'b1;
    end else begin
      case (cur)
        4'd0:    ok = (nxt == 4'd1) || (nxt == 4'd2);
        4'd1:    ok = (nxt == 4'd2) || (nxt == 4'd4);
        4'd2:    ok = (nxt == 4'd3);
        4'd3:    ok = (nxt == 4'd0) || (nxt == 4'd1) || (nxt == 4'd5);
        4'd4:    ok = (nxt == 4'd0) || (nxt == 4'd5);
        4'd5:    ok = (nxt == 4'd1) || (nxt == 4'd6);
        4'd6:    ok = (nxt == 4'd0) || (nxt == 4'd7);
        4'd7:    ok = (nxt == 4'd0);
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/state_seq.sv
// Sequencer that owns the shared 4-bit state field. Requests arrive over a
// valid/ready handshake and are committed only when legal and after the
// minimum dwell; abort and dwell expiry force a return to state 0.
module state_seq
  import state_seq_pkg::*;
#(
  parameter int MIN_DWELL = 4,
  parameter int MAX_DWELL = 255,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_i,
  input  logic [3:0]       req_state_i,
  output logic             req_ready_o,
  input  logic             abort_i,
  output logic [3:0]       state_o,
  output logic             err_illegal_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] trans_cnt_o
);

  localparam int DW_W = $clog2(MAX_DWELL + 1);
  localparam logic [DW_W-1:0] READY_AT = DW_W'(MIN_DWELL - 1);
  localparam logic [DW_W-1:0] DWELL_MAX = DW_W'(MAX_DWELL);

  state_t           state_q;
  logic [DW_W-1:0]  dwellCnt_q;
  logic [CNT_W-1:0] transCnt_q;
  logic             errIllegal_q;
  logic             timeout_q;

  logic             accept;
  logic             reqLegal;
  logic [DW_W-1:0]  dwellInc_d;
  logic [CNT_W-1:0] transInc_d;

  // Handshake readiness depends only on registered dwell and the live abort.
  always_comb begin
    req_ready_o = (dwellCnt_q >= READY_AT) && !abort_i;
    accept      = req_valid_i && req_ready_o;
    reqLegal    = legal_next(state_q, req_state_i);
    dwellInc_d  = (dwellCnt_q == DWELL_MAX) ? dwellCnt_q : dwellCnt_q + 1'b1;
    transInc_d  = (transCnt_q == '1) ? transCnt_q : transCnt_q + 1'b1;
  end

  // Sequencer state, dwell timer, transition counter and the one-cycle pulses,
  // with abort taking precedence over an accepted request, then dwell expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S0;
      dwellCnt_q   <= '0;
      transCnt_q   <= '0;
      errIllegal_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      errIllegal_q <= 1'b0;
      timeout_q    <= 1'b0;
      if (abort_i) begin
        if (state_q != S0) begin
          state_q    <= S0;
          dwellCnt_q <= '0;
          transCnt_q <= transInc_d;
        end else begin
          dwellCnt_q <= dwellInc_d;
        end
      end else if (accept) begin
        if (!reqLegal) begin
          errIllegal_q <= 1'b1;
          dwellCnt_q   <= dwellInc_d;
        end else if (req_state_i != state_q) begin
          state_q    <= state_t'(req_state_i);
          dwellCnt_q <= '0;
          transCnt_q <= transInc_d;
        end else begin
          dwellCnt_q <= dwellInc_d;
        end
      end else if ((state_q != S0) && (dwellCnt_q == DWELL_MAX)) begin
        state_q    <= S0;
        dwellCnt_q <= '0;
        transCnt_q <= transInc_d;
        timeout_q  <= 1'b1;
      end else begin
        dwellCnt_q <= dwellInc_d;
      end
    end
  end

  assign state_o       = state_q;
  assign err_illegal_o = errIllegal_q;
  assign timeout_o     = timeout_q;
  assign trans_cnt_o   = transCnt_q;

  default clocking cb @(posedge clk);
  endclocking

  // Only the eight defined states are ever driven.
  aStateRange : assert property (disable iff (!rst_n) !state_q[3]);

  // The monitor's rule: state 1 may only be entered from 0, 3 or 5.
  aEntryToOne : assert property (disable iff (!rst_n)
    (state_q == S1 && $past(state_q) != S1) |-> ($past(state_q) inside {S0, S3, S5}));

  // Abort always blocks the handshake.
  aAbortBlocks : assert property (disable iff (!rst_n) abort_i |-> !req_ready_o);

endmodule

// File: tb/tb_state_seq.sv
// Directed bench for state_seq: a vector table of handshake requests with
// hand-computed results, plus hand-written sequences for reset, timeout,
// abort and counter saturation.
module tb_state_seq;

  logic        clk;
  logic        rst_n;
  logic        reqValid;
  logic [3:0]  reqState;
  logic        reqReady;
  logic        abortIn;
  logic [3:0]  stateOut;
  logic        errIllegal;
  logic        timeoutOut;
  logic [15:0] transCnt;

  logic        satValid;
  logic [3:0]  satReqState;
  logic        satReady;
  logic [3:0]  satState;
  logic        satErr;
  logic        satTimeout;
  logic [2:0]  satCnt;

  int testsRun;
  int testsFailed;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  expState;
    logic        expErr;
    logic [15:0] expCnt;
  } vec_t;

  vec_t vecs[20];

  state_seq #(.MIN_DWELL(4), .MAX_DWELL(255), .CNT_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (reqValid),
    .req_state_i   (reqState),
    .req_ready_o   (reqReady),
    .abort_i       (abortIn),
    .state_o       (stateOut),
    .err_illegal_o (errIllegal),
    .timeout_o     (timeoutOut),
    .trans_cnt_o   (transCnt)
  );

  // Narrow-counter instance so saturation is reachable in a few cycles.
  state_seq #(.MIN_DWELL(1), .MAX_DWELL(3), .CNT_W(3)) dutSat (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (satValid),
    .req_state_i   (satReqState),
    .req_ready_o   (satReady),
    .abort_i       (1'b0),
    .state_o       (satState),
    .err_illegal_o (satErr),
    .timeout_o     (satTimeout),
    .trans_cnt_o   (satCnt)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n    = 1'b0;
    reqValid = 1'b0;
    abortIn  = 1'b0;
    satValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Present a request, hold it until ready, let it be accepted, then drop it.
  task automatic applyStimulus(input logic [3:0] req);
    int waited;
    reqValid = 1'b1;
    reqState = req;
    waited   = 0;
    while (!reqReady && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!reqReady) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL readyWait: got ready 0, expected 1 within 20 cycles");
    end
    @(negedge clk);
    reqValid = 1'b0;
  endtask

  initial begin
    int n;
    logic [3:0] seq7[7];
    testsRun    = 0;
    testsFailed = 0;
    rst_n       = 1'b1;
    reqValid    = 1'b0;
    reqState    = 4'd0;
    abortIn     = 1'b0;
    satValid    = 1'b0;
    satReqState = 4'd0;

    vecs[0]  = '{4'd2, 4'd2, 1'b0, 16'd1};
    vecs[1]  = '{4'd3, 4'd3, 1'b0, 16'd2};
    vecs[2]  = '{4'd5, 4'd5, 1'b0, 16'd3};
    vecs[3]  = '{4'd1, 4'd1, 1'b0, 16'd4};
    vecs[4]  = '{4'd4, 4'd4, 1'b0, 16'd5};
    vecs[5]  = '{4'd5, 4'd5, 1'b0, 16'd6};
    vecs[6]  = '{4'd6, 4'd6, 1'b0, 16'd7};
    vecs[7]  = '{4'd7, 4'd7, 1'b0, 16'd8};
    vecs[8]  = '{4'd0, 4'd0, 1'b0, 16'd9};
    vecs[9]  = '{4'd3, 4'd0, 1'b1, 16'd9};
    vecs[10] = '{4'd0, 4'd0, 1'b0, 16'd9};
    vecs[11] = '{4'd1, 4'd1, 1'b0, 16'd10};
    vecs[12] = '{4'd3, 4'd1, 1'b1, 16'd10};
    vecs[13] = '{4'd9, 4'd1, 1'b1, 16'd10};
    vecs[14] = '{4'd1, 4'd1, 1'b0, 16'd10};
    vecs[15] = '{4'd0, 4'd1, 1'b1, 16'd10};
    vecs[16] = '{4'd15, 4'd1, 1'b1, 16'd10};
    vecs[17] = '{4'd4, 4'd4, 1'b0, 16'd11};
    vecs[18] = '{4'd7, 4'd4, 1'b1, 16'd11};
    vecs[19] = '{4'd8, 4'd4, 1'b1, 16'd11};

    // Reset values while reset is held.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rstState", 32'(stateOut), 32'd0);
    checkOutput("rstCnt", 32'(transCnt), 32'd0);
    checkOutput("rstReady", 32'(reqReady), 32'd0);
    checkOutput("rstErr", 32'(errIllegal), 32'd0);
    checkOutput("rstTimeout", 32'(timeoutOut), 32'd0);

    // First request after release: ready at the 3rd edge, state 1 at the 4th.
    @(negedge clk);
    rst_n    = 1'b1;
    reqValid = 1'b1;
    reqState = 4'd1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("firstReadyEdge2", 32'(reqReady), 32'd0);
    @(negedge clk);
    checkOutput("firstReadyEdge3", 32'(reqReady), 32'd1);
    checkOutput("firstStateEdge3", 32'(stateOut), 32'd0);
    @(negedge clk);
    reqValid = 1'b0;
    checkOutput("firstStateEdge4", 32'(stateOut), 32'd1);
    checkOutput("firstCnt", 32'(transCnt), 32'd1);
    checkOutput("firstReadyAfter", 32'(reqReady), 32'd0);

    // Table walk from a fresh reset, including illegal and self requests.
    doReset();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].req);
      checkOutput($sformatf("vec%0d.state", i), 32'(stateOut), 32'(vecs[i].expState));
      checkOutput($sformatf("vec%0d.err", i), 32'(errIllegal), 32'(vecs[i].expErr));
      checkOutput($sformatf("vec%0d.cnt", i), 32'(transCnt), 32'(vecs[i].expCnt));
      @(negedge clk);
      checkOutput($sformatf("vec%0d.errDrop", i), 32'(errIllegal), 32'd0);
    end

    // Timeout: idle in state 4 until forced back to 0 after 256 edges.
    doReset();
    applyStimulus(4'd1);
    applyStimulus(4'd4);
    checkOutput("toEntry", 32'(stateOut), 32'd4);
    n = 0;
    while (stateOut != 4'd0 && n < 400) begin
      @(negedge clk);
      n++;
      if (stateOut != 4'd0) begin
        checkOutput("toEarlyPulse", 32'(timeoutOut), 32'd0);
      end
    end
    checkOutput("toCycles", 32'(n), 32'd256);
    checkOutput("toState", 32'(stateOut), 32'd0);
    checkOutput("toPulse", 32'(timeoutOut), 32'd1);
    checkOutput("toCnt", 32'(transCnt), 32'd3);
    checkOutput("toDwellRestart", 32'(reqReady), 32'd0);
    @(negedge clk);
    checkOutput("toPulseDrop", 32'(timeoutOut), 32'd0);

    // Abort in state 2 while a legal request is ready.
    applyStimulus(4'd2);
    checkOutput("abEntry", 32'(stateOut), 32'd2);
    repeat (4) @(negedge clk);
    checkOutput("abReadyBefore", 32'(reqReady), 32'd1);
    reqValid = 1'b1;
    reqState = 4'd3;
    abortIn  = 1'b1;
    #1;
    checkOutput("abReadyBlocked", 32'(reqReady), 32'd0);
    @(negedge clk);
    checkOutput("abState", 32'(stateOut), 32'd0);
    checkOutput("abCnt", 32'(transCnt), 32'd5);
    checkOutput("abNoErr", 32'(errIllegal), 32'd0);
    reqValid = 1'b0;
    abortIn  = 1'b0;

    // Abort in state 0 is a no-op for the counter.
    repeat (4) @(negedge clk);
    reqValid = 1'b1;
    reqState = 4'd1;
    abortIn  = 1'b1;
    #1;
    checkOutput("ab0Ready", 32'(reqReady), 32'd0);
    @(negedge clk);
    checkOutput("ab0State", 32'(stateOut), 32'd0);
    checkOutput("ab0Cnt", 32'(transCnt), 32'd5);
    reqValid = 1'b0;
    abortIn  = 1'b0;

    // Asynchronous reset mid-dwell in state 5 with seven transitions counted.
    doReset();
    seq7 = '{4'd2, 4'd3, 4'd5, 4'd1, 4'd2, 4'd3, 4'd5};
    foreach (seq7[i]) applyStimulus(seq7[i]);
    checkOutput("arPreState", 32'(stateOut), 32'd5);
    checkOutput("arPreCnt", 32'(transCnt), 32'd7);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arState", 32'(stateOut), 32'd0);
    checkOutput("arCnt", 32'(transCnt), 32'd0);
    checkOutput("arErr", 32'(errIllegal), 32'd0);
    checkOutput("arTimeout", 32'(timeoutOut), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Saturation on the narrow instance: cycle 0-1-2-3-0 one change per edge.
    satValid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      case (satState)
        4'd0:    satReqState = 4'd1;
        4'd1:    satReqState = 4'd2;
        4'd2:    satReqState = 4'd3;
        default: satReqState = 4'd0;
      endcase
      @(negedge clk);
      if (k == 6) checkOutput("satCnt6", 32'(satCnt), 32'd6);
      if (k == 7) checkOutput("satCnt7", 32'(satCnt), 32'd7);
    end
    checkOutput("satHold", 32'(satCnt), 32'd7);
    checkOutput("satNoErr", 32'(satErr), 32'd0);
    satValid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
